expmod_scheduler: RTL and testbench

//  Shares one exponent_modulus engine between NUM_REQ requesters (UART job path, key-gen, self-test).

---
 rtl/expmod_scheduler.sv | 212 +++++++++++++++++++++
 tb/tb_expmod_scheduler.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/expmod_scheduler.sv
// expmod_scheduler: round-robin front end that shares one exponent_modulus engine
// between NUM_REQ requesters.
//
// Flow: the scheduler accepts one job from the round-robin winner and latches its
// operands. It issues a one-cycle start to the engine, waits for the engine result,
// then holds that result for the winner until the winner accepts it. A modulus of
// 0 or 1 is answered directly, without starting the engine.
//
// Optional feature: EXPMOD_SCHED_TIMEOUT_EN adds a 16-bit watchdog in WAIT. When
// the watchdog expires, the job is answered with err=1 and data=0.
//
// Ports:
//   clk_in, rst_n_in        clock, async active-low reset
//   req_valid_in/ready_out  per-requester job handshake (ready is one-hot or zero)
//   req_value/exp/mod_in    packed per-requester operands, slot i at [i*W +: W]
//   eng_start_out           one-cycle start to the engine
//   eng_value/exp/mod_out   latched operands of the accepted job
//   eng_busy_in             engine busy; start is held off while high
//   eng_valid_in            one-cycle engine result strobe
//   eng_result_in           engine result
//   rsp_valid_out           one-hot result valid for the granted requester
//   rsp_ready_in            per-requester result accept
//   rsp_data_out            result shared by all requesters
//   rsp_err_out             1 = rsp_data_out carries no valid result
//   busy_out                high whenever a job is in flight
module expmod_scheduler #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned KEY_WIDTH      = 32,
  parameter int unsigned MSG_WIDTH      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                           clk_in,
  input  logic                           rst_n_in,
  input  logic [NUM_REQ-1:0]             req_valid_in,
  output logic [NUM_REQ-1:0]             req_ready_out,
  input  logic [NUM_REQ*MSG_WIDTH-1:0]   req_value_in,
  input  logic [NUM_REQ*KEY_WIDTH-1:0]   req_exp_in,
  input  logic [NUM_REQ*KEY_WIDTH-1:0]   req_mod_in,
  output logic                           eng_start_out,
  output logic [MSG_WIDTH-1:0]           eng_value_out,
  output logic [KEY_WIDTH-1:0]           eng_exp_out,
  output logic [KEY_WIDTH-1:0]           eng_mod_out,
  input  logic                           eng_busy_in,
  input  logic                           eng_valid_in,
  input  logic [KEY_WIDTH-1:0]           eng_result_in,
  output logic [NUM_REQ-1:0]             rsp_valid_out,
  input  logic [NUM_REQ-1:0]             rsp_ready_in,
  output logic [KEY_WIDTH-1:0]           rsp_data_out,
  output logic                           rsp_err_out,
  output logic                           busy_out
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  // Reject configurations the index and watchdog widths cannot represent.
  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536) begin : g_bad_param
    $error("expmod_scheduler: parameter out of range");
  end

  logic [1:0]           state_q, state_d;
  // Index of the current or most recent grant. It doubles as the round-robin
  // pointer: a job leaves RESP only through its handshake or through reset, so at
  // arbitration time this register always holds the last served requester.
  logic [IDX_W-1:0]     grant_q, grant_d;
  logic [MSG_WIDTH-1:0] value_q, value_d;
  logic [KEY_WIDTH-1:0] exp_q, exp_d;
  logic [KEY_WIDTH-1:0] mod_q, mod_d;
  logic [KEY_WIDTH-1:0] data_q, data_d;
  logic                 err_q, err_d;
`ifdef EXPMOD_SCHED_TIMEOUT_EN
  logic [15:0]          wdog_q, wdog_d;
`endif

  logic                 any_req_c;
  logic [IDX_W-1:0]     pick_c;
  logic [IDX_W-1:0]     scan_c;
  logic [KEY_WIDTH-1:0] sel_mod_c;

  // Round-robin pick: scan offsets from largest to 1, so the smallest offset
  // after the pointer is written last and wins.
  always_comb begin
    any_req_c = 1'b0;
    pick_c    = '0;
    scan_c    = '0;
    for (int unsigned k = NUM_REQ; k >= 1; k--) begin
      scan_c = IDX_W'((32'(grant_q) + k) % NUM_REQ);
      if (req_valid_in[scan_c]) begin
        any_req_c = 1'b1;
        pick_c    = scan_c;
      end
    end
    sel_mod_c = req_mod_in[32'(pick_c)*KEY_WIDTH +: KEY_WIDTH];
  end

  // Next-state and combinational handshake outputs.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    value_d       = value_q;
    exp_d         = exp_q;
    mod_d         = mod_q;
    data_d        = data_q;
    err_d         = err_q;
    req_ready_out = '0;
    eng_start_out = 1'b0;
`ifdef EXPMOD_SCHED_TIMEOUT_EN
    wdog_d        = wdog_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (any_req_c) begin
          req_ready_out[pick_c] = 1'b1;
          grant_d = pick_c;
          value_d = req_value_in[32'(pick_c)*MSG_WIDTH +: MSG_WIDTH];
          exp_d   = req_exp_in[32'(pick_c)*KEY_WIDTH +: KEY_WIDTH];
          mod_d   = sel_mod_c;
          // Moduli 0 and 1 have trivial answers, so the engine is skipped.
          if (sel_mod_c == '0) begin
            data_d  = '0;
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else if (sel_mod_c == KEY_WIDTH'(1)) begin
            data_d  = '0;
            err_d   = 1'b0;
            state_d = ST_RESP;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (!eng_busy_in) begin
          eng_start_out = 1'b1;
          state_d       = ST_WAIT;
`ifdef EXPMOD_SCHED_TIMEOUT_EN
          wdog_d        = '0;
`endif
        end
      end
      ST_WAIT: begin
        // A real result takes priority over a watchdog expiry in the same cycle.
        if (eng_valid_in) begin
          data_d  = eng_result_in;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end
`ifdef EXPMOD_SCHED_TIMEOUT_EN
        else if (wdog_q == 16'(TIMEOUT_CYCLES - 1)) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          wdog_d = wdog_q + 16'd1;
        end
`endif
      end
      default: begin
        if (rsp_ready_in[grant_q]) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= ST_IDLE;
      grant_q <= IDX_W'(NUM_REQ - 1);
      value_q <= '0;
      exp_q   <= '0;
      mod_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
`ifdef EXPMOD_SCHED_TIMEOUT_EN
      wdog_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      value_q <= value_d;
      exp_q   <= exp_d;
      mod_q   <= mod_d;
      data_q  <= data_d;
      err_q   <= err_d;
`ifdef EXPMOD_SCHED_TIMEOUT_EN
      wdog_q  <= wdog_d;
`endif
    end
  end

  // Response valid is a decode of registered state and grant.
  always_comb begin
    rsp_valid_out = '0;
    if (state_q == ST_RESP) begin
      rsp_valid_out[grant_q] = 1'b1;
    end
  end

  assign eng_value_out = value_q;
  assign eng_exp_out   = exp_q;
  assign eng_mod_out   = mod_q;
  assign rsp_data_out  = data_q;
  assign rsp_err_out   = err_q;
  assign busy_out      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_expmod_scheduler.sv
// Directed bench for expmod_scheduler, with a behavioural engine model.
module tb_expmod_scheduler;

  localparam int unsigned NUM_REQ        = 4;
  localparam int unsigned KEY_WIDTH      = 32;
  localparam int unsigned MSG_WIDTH      = 16;
  localparam int unsigned TIMEOUT_CYCLES = 16;
  localparam int unsigned ENG_LAT        = 3;

  logic                         clk_in       = 1'b0;
  logic                         rst_n_in     = 1'b0;
  logic [NUM_REQ-1:0]           req_valid_in = '0;
  logic [NUM_REQ-1:0]           req_ready_out;
  logic [NUM_REQ*MSG_WIDTH-1:0] req_value_in = '0;
  logic [NUM_REQ*KEY_WIDTH-1:0] req_exp_in   = '0;
  logic [NUM_REQ*KEY_WIDTH-1:0] req_mod_in   = '0;
  logic                         eng_start_out;
  logic [MSG_WIDTH-1:0]         eng_value_out;
  logic [KEY_WIDTH-1:0]         eng_exp_out;
  logic [KEY_WIDTH-1:0]         eng_mod_out;
  logic                         eng_busy_in;
  logic                         eng_valid_in;
  logic [KEY_WIDTH-1:0]         eng_result_in;
  logic [NUM_REQ-1:0]           rsp_valid_out;
  logic [NUM_REQ-1:0]           rsp_ready_in = '0;
  logic [KEY_WIDTH-1:0]         rsp_data_out;
  logic                         rsp_err_out;
  logic                         busy_out;

  expmod_scheduler #(
    .NUM_REQ(NUM_REQ), .KEY_WIDTH(KEY_WIDTH), .MSG_WIDTH(MSG_WIDTH),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
    .req_value_in(req_value_in), .req_exp_in(req_exp_in), .req_mod_in(req_mod_in),
    .eng_start_out(eng_start_out), .eng_value_out(eng_value_out),
    .eng_exp_out(eng_exp_out), .eng_mod_out(eng_mod_out),
    .eng_busy_in(eng_busy_in), .eng_valid_in(eng_valid_in), .eng_result_in(eng_result_in),
    .rsp_valid_out(rsp_valid_out), .rsp_ready_in(rsp_ready_in),
    .rsp_data_out(rsp_data_out), .rsp_err_out(rsp_err_out), .busy_out(busy_out)
  );

  always #5 clk_in = ~clk_in;

  // Reference modular exponentiation (square-and-multiply).
  function automatic logic [31:0] model(input logic [31:0] b, input logic [31:0] e, input logic [31:0] m);
    logic [63:0] r, x, mm;
    if (m == 32'd0) return 32'd0;
    mm = 64'(m);
    r  = 64'd1 % mm;
    x  = 64'(b) % mm;
    for (int i = 0; i < 32; i++) begin
      if (e[i]) r = (r * x) % mm;
      x = (x * x) % mm;
    end
    return r[31:0];
  endfunction

  // Engine model: fixed latency; eng_en=0 makes it silent. stray_valid injects a pulse.
  logic                 eng_en      = 1'b1;
  logic                 busy_force  = 1'b0;
  logic                 stray_valid = 1'b0;
  logic [KEY_WIDTH-1:0] stray_data  = '0;
  logic                 eng_run     = 1'b0;
  logic                 eng_valid_m = 1'b0;
  logic [7:0]           eng_cnt     = '0;
  logic [KEY_WIDTH-1:0] eng_res     = '0;
  int                   start_cnt   = 0;

  always @(posedge clk_in) begin
    eng_valid_m <= 1'b0;
    if (eng_start_out) start_cnt <= start_cnt + 1;
    if (eng_run) begin
      if (eng_cnt == 8'd0) begin
        eng_valid_m <= eng_en;
        eng_run     <= 1'b0;
      end else begin
        eng_cnt <= eng_cnt - 8'd1;
      end
    end else if (eng_start_out) begin
      eng_run <= 1'b1;
      eng_cnt <= 8'(ENG_LAT - 1);
      eng_res <= model(32'(eng_value_out), eng_exp_out, eng_mod_out);
    end
  end

  assign eng_busy_in   = eng_run | busy_force;
  assign eng_valid_in  = eng_valid_m | stray_valid;
  assign eng_result_in = stray_valid ? stray_data : eng_res;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] oh(input int g);
    logic [3:0] r;
    r = 4'b0001 << g;
    return r;
  endfunction

  task automatic set_ops(input logic [15:0] base, input logic [31:0] ex, input logic [31:0] md);
    for (int i = 0; i < 4; i++) begin
      req_value_in[i*16 +: 16] = base + 16'(i);
      req_exp_in[i*32 +: 32]   = ex;
      req_mod_in[i*32 +: 32]   = md;
    end
  endtask

  task automatic scramble();
    req_value_in = {$urandom, $urandom};
    req_exp_in   = {$urandom, $urandom, $urandom, $urandom};
    req_mod_in   = {$urandom, $urandom, $urandom, $urandom};
  endtask

  typedef struct {
    logic [3:0]  valid;
    logic [15:0] base;   // requester i gets base+i
    logic [31:0] ex;
    logic [31:0] md;
    int          g;
    logic        err;
    logic [31:0] data;
    int          starts;
  } vec_t;

  vec_t tbl[11];

  // One full job: grant check, operand scramble, response, ignored foreign ready, handshake.
  task automatic run_row(input vec_t v, input string tag);
    int s0, n, viol;
    @(negedge clk_in);
    req_valid_in = v.valid;
    set_ops(v.base, v.ex, v.md);
    s0 = start_cnt;
    #1;
    check({tag, "_ready"}, 64'(req_ready_out), 64'(oh(v.g)));
    check({tag, "_idle"},  64'(busy_out), 64'd0);
    @(negedge clk_in);
    scramble();
    check({tag, "_busy"}, 64'(busy_out), 64'd1);
    n = 0; viol = 0;
    while (rsp_valid_out == '0 && n < 100) begin
      if (req_ready_out != '0) viol++;
      @(negedge clk_in);
      n++;
    end
    check({tag, "_rspv"},   64'(rsp_valid_out), 64'(oh(v.g)));
    check({tag, "_data"},   64'(rsp_data_out), 64'(v.data));
    check({tag, "_err"},    64'(rsp_err_out), 64'(v.err));
    check({tag, "_starts"}, 64'(start_cnt - s0), 64'(v.starts));
    check({tag, "_nogrant"}, 64'(viol), 64'd0);
    rsp_ready_in = ~oh(v.g);
    @(negedge clk_in);
    check({tag, "_ignore"}, 64'(rsp_valid_out), 64'(oh(v.g)));
    rsp_ready_in = oh(v.g);
    @(posedge clk_in); #1;
    rsp_ready_in = '0;
    check({tag, "_done"},     64'(rsp_valid_out), 64'd0);
    check({tag, "_doneidle"}, 64'(busy_out), 64'd0);
  endtask

  initial begin
    int n, viol, s0;
    tbl[0]  = '{4'b0001, 16'd4,  32'd13, 32'd497,  0, 1'b0, 32'd445, 1};
    tbl[1]  = '{4'b1111, 16'd3,  32'd5,  32'd1000, 1, 1'b0, 32'd24,  1};
    tbl[2]  = '{4'b1111, 16'd3,  32'd5,  32'd1000, 2, 1'b0, 32'd125, 1};
    tbl[3]  = '{4'b1111, 16'd3,  32'd5,  32'd1000, 3, 1'b0, 32'd776, 1};
    tbl[4]  = '{4'b1111, 16'd3,  32'd5,  32'd1000, 0, 1'b0, 32'd243, 1};
    tbl[5]  = '{4'b0100, 16'd3,  32'd5,  32'd0,    2, 1'b1, 32'd0,   0};
    tbl[6]  = '{4'b0100, 16'd3,  32'd5,  32'd1,    2, 1'b0, 32'd0,   0};
    tbl[7]  = '{4'b1001, 16'd2,  32'd10, 32'd1000, 3, 1'b0, 32'd625, 1};
    tbl[8]  = '{4'b0010, 16'd7,  32'd2,  32'd100,  1, 1'b0, 32'd64,  1};
    tbl[9]  = '{4'b0011, 16'd9,  32'd2,  32'd50,   0, 1'b0, 32'd31,  1};
    tbl[10] = '{4'b0001, 16'd10, 32'd3,  32'd7,    0, 1'b0, 32'd6,   1};

    // Reset state.
    #1;
    check("rst_busy",  64'(busy_out), 64'd0);
    check("rst_rspv",  64'(rsp_valid_out), 64'd0);
    check("rst_ops",   64'({eng_value_out, eng_exp_out}), 64'd0);
    check("rst_data",  64'({rsp_data_out, rsp_err_out, eng_start_out}), 64'd0);
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;

    for (int r = 0; r < 11; r++) run_row(tbl[r], $sformatf("row%0d", r));

    // Engine busy for 5 cycles in ISSUE, then a 10-cycle response stall.
    @(negedge clk_in);
    busy_force   = 1'b1;
    req_valid_in = 4'b0001;
    set_ops(16'd3, 32'd3, 32'd100);
    s0 = start_cnt;
    #1;
    check("hold_ready", 64'(req_ready_out), 64'b0001);
    @(negedge clk_in);
    req_valid_in = '0;
    scramble();
    check("hold_latch", 64'({eng_value_out, eng_mod_out}), {16'd0, 16'd3, 32'd100});
    check("hold_exp",   64'(eng_exp_out), 64'd3);
    viol = 0;
    for (int i = 0; i < 5; i++) begin
      if (eng_start_out !== 1'b0 || busy_out !== 1'b1) viol++;
      @(negedge clk_in);
    end
    check("hold_nostart", 64'(viol), 64'd0);
    busy_force = 1'b0;
    #1;
    check("hold_start", 64'(eng_start_out), 64'd1);
    @(negedge clk_in);
    check("hold_pulse", 64'(eng_start_out), 64'd0);
    n = 0;
    while (rsp_valid_out == '0 && n < 100) begin @(negedge clk_in); n++; end
    req_valid_in = 4'b1111;
    viol = 0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid_out !== 4'b0001 || rsp_data_out !== 32'd27 || rsp_err_out !== 1'b0 ||
          req_ready_out !== 4'b0000) viol++;
      @(negedge clk_in);
    end
    check("stall_stable", 64'(viol), 64'd0);
    check("stall_data",   64'(rsp_data_out), 64'd27);
    check("stall_starts", 64'(start_cnt - s0), 64'd1);
    rsp_ready_in = 4'b0001;
    @(posedge clk_in); #1;
    rsp_ready_in = '0;
    check("stall_done",  64'(rsp_valid_out), 64'd0);
    check("stall_next",  64'(req_ready_out), 64'b0010);
    req_valid_in = '0;

    // Valid dropped before any clock edge: no accept, pointer unchanged.
    @(negedge clk_in);
    req_valid_in = 4'b0100;
    #1;
    check("drop_ready", 64'(req_ready_out), 64'b0100);
    #2;
    req_valid_in = '0;
    @(negedge clk_in);
    check("drop_idle", 64'(busy_out), 64'd0);
    req_valid_in = 4'b1111;
    #1;
    check("drop_ptr", 64'(req_ready_out), 64'b0010);
    req_valid_in = '0;

    // Reset in WAIT with a silent engine, then a stray engine result.
    @(negedge clk_in);
    eng_en       = 1'b0;
    req_valid_in = 4'b0010;
    set_ops(16'd5, 32'd3, 32'd1000);
    @(negedge clk_in);
    req_valid_in = '0;
    n = 0;
    while (eng_start_out !== 1'b1 && n < 20) begin @(negedge clk_in); n++; end
    repeat (3) @(negedge clk_in);
    check("mid_busy", 64'(busy_out), 64'd1);
    rst_n_in = 1'b0;
    #1;
    check("mid_rst_ctl",  64'({busy_out, rsp_valid_out, eng_start_out, rsp_err_out, req_ready_out}), 64'd0);
    check("mid_rst_ops",  64'({eng_value_out, eng_mod_out}), 64'd0);
    check("mid_rst_exp",  64'(eng_exp_out), 64'd0);
    check("mid_rst_data", 64'(rsp_data_out), 64'd0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(negedge clk_in);
    stray_data  = 32'hDEAD_BEEF;
    stray_valid = 1'b1;
    @(negedge clk_in);
    stray_valid = 1'b0;
    check("stray_state", 64'({busy_out, rsp_valid_out}), 64'd0);
    check("stray_data",  64'(rsp_data_out), 64'd0);
    req_valid_in = 4'b1111;
    #1;
    check("post_rst_grant", 64'(req_ready_out), 64'b0001);
    req_valid_in = '0;

`ifdef EXPMOD_SCHED_TIMEOUT_EN
    // Watchdog: silent engine answers with err after TIMEOUT_CYCLES WAIT cycles.
    @(negedge clk_in);
    req_valid_in = 4'b0001;
    set_ops(16'd6, 32'd7, 32'd1000);
    @(negedge clk_in);
    req_valid_in = '0;
    n = 0;
    while (eng_start_out !== 1'b1 && n < 20) begin @(negedge clk_in); n++; end
    n = 0;
    while (rsp_valid_out == '0 && n < 100) begin @(negedge clk_in); n++; end
    check("wdog_cycles", 64'(n), 64'(TIMEOUT_CYCLES + 1));
    check("wdog_rspv",   64'(rsp_valid_out), 64'b0001);
    check("wdog_err",    64'(rsp_err_out), 64'd1);
    check("wdog_data",   64'(rsp_data_out), 64'd0);
    rsp_ready_in = 4'b0001;
    @(posedge clk_in); #1;
    rsp_ready_in = '0;
    check("wdog_done", 64'(busy_out), 64'd0);
`else
    // No watchdog: a silent engine leaves the job waiting indefinitely.
    @(negedge clk_in);
    req_valid_in = 4'b0001;
    set_ops(16'd6, 32'd7, 32'd1000);
    @(negedge clk_in);
    req_valid_in = '0;
    repeat (40) @(negedge clk_in);
    check("nowdog_hold", 64'({busy_out, rsp_valid_out}), 64'b10000);
    rst_n_in = 1'b0;
    @(negedge clk_in);
    rst_n_in = 1'b1;
`endif
    eng_en = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before finish");
    $fatal(1, "time limit");
  end

endmodule
